// File: rtl/router_fsm_nch_if.sv
// router_fsm_nch_if -- signal bundle between the packet source / FIFO side
// and the router control FSM.
//   master : packet source + FIFO status side (drives FSM inputs)
//   slave  : router_fsm_nch (drives state decodes, sel_ch, pulses)
// Parameters: NUM_CH output channels, ADDR_W header address width.
interface router_fsm_nch_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2
);
    logic              pkt_valid;
    logic [ADDR_W-1:0] din_addr;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] soft_rst;
    logic              parity_done;
    logic              low_pkt_valid;

    logic              detect_addr;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              rst_int_reg;
    logic              wr_en_req;
    logic              busy;
    logic [ADDR_W-1:0] sel_ch;
    logic              addr_err;
    logic              drop_pkt;

    modport master (
        output pkt_valid, din_addr, fifo_full, fifo_empty, soft_rst,
               parity_done, low_pkt_valid,
        input  detect_addr, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, wr_en_req, busy, sel_ch, addr_err, drop_pkt
    );

    modport slave (
        input  pkt_valid, din_addr, fifo_full, fifo_empty, soft_rst,
               parity_done, low_pkt_valid,
        output detect_addr, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, wr_en_req, busy, sel_ch, addr_err, drop_pkt
    );
endinterface

// File: rtl/router_fsm_nch.sv
// router_fsm_nch -- control FSM of an N-channel packet router.
// Decodes the header address, waits for the destination FIFO to drain,
// steers payload/parity writes and handles FIFO-full back-pressure.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   bus   : router_fsm_nch_if.slave (packet/FIFO status in, state decodes,
//           sel_ch, addr_err / drop_pkt pulses out)
// Parameters: NUM_CH (2..16), ADDR_W (NUM_CH <= 2**ADDR_W),
//             TIMEOUT_CYC (1..65535, used only with the timeout feature).
// Build option: define ROUTER_WAIT_TIMEOUT_EN to enable the
// WAIT_TILL_EMPTY timeout that discards the packet via DROP_PACKET.
// Without it there is no counter, DROP_PACKET is unreachable and
// drop_pkt is tied low.
module router_fsm_nch #(
    parameter int NUM_CH      = 3,
    parameter int ADDR_W      = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input logic            clk,
    input logic            rst,
    router_fsm_nch_if.slave bus
);

    if (NUM_CH < 2 || NUM_CH > 16 || NUM_CH > (1 << ADDR_W) ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
        $error("router_fsm_nch: illegal parameter combination");
    end

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        WAIT_TILL_EMPTY    = 4'd3,
        FIFO_FULL_STATE    = 4'd4,
        LOAD_AFTER_FULL    = 4'd5,
        LOAD_PARITY        = 4'd6,
        CHECK_PARITY_ERROR = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] sel_q, sel_d;
    logic              addr_ok, din_empty;
    logic              sel_full, sel_empty, sel_srst;
    logic              addr_err_c, drop_c;
    logic              timeout_hit;

    // Channel lookups by loop so an address wider than the channel count
    // never indexes past the end of the per-channel vectors.
    always_comb begin
        addr_ok   = 1'b0;
        din_empty = 1'b0;
        sel_full  = 1'b0;
        sel_empty = 1'b0;
        sel_srst  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.din_addr == ADDR_W'(i)) begin
                addr_ok   = 1'b1;
                din_empty = bus.fifo_empty[i];
            end
            if (sel_q == ADDR_W'(i)) begin
                sel_full  = bus.fifo_full[i];
                sel_empty = bus.fifo_empty[i];
                sel_srst  = bus.soft_rst[i];
            end
        end
    end

`ifdef ROUTER_WAIT_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // Held at zero outside WAIT_TILL_EMPTY, so it reads 0 on the first
    // waiting cycle and TIMEOUT_CYC-1 on the last one allowed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wait_cnt <= '0;
        else if (state == WAIT_TILL_EMPTY)
            wait_cnt <= wait_cnt + 16'd1;
        else
            wait_cnt <= '0;
    end

    assign timeout_hit = (wait_cnt == 16'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DECODE_ADDRESS;
            sel_q <= '0;
        end else begin
            state <= next_state;
            sel_q <= sel_d;
        end
    end

    always_comb begin
        next_state = state;
        sel_d      = sel_q;
        addr_err_c = 1'b0;
        drop_c     = 1'b0;
        case (state)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid) begin
                    if (addr_ok) begin
                        sel_d      = bus.din_addr;
                        next_state = din_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end else begin
                        addr_err_c = 1'b1;
                    end
                end
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (sel_full)
                    next_state = FIFO_FULL_STATE;
                else if (!bus.pkt_valid)
                    next_state = LOAD_PARITY;
            end
            WAIT_TILL_EMPTY: begin
                // Drain on the expiry cycle still wins over the timeout.
                if (sel_empty) begin
                    next_state = LOAD_FIRST_DATA;
                end else if (timeout_hit) begin
                    next_state = DROP_PACKET;
                    drop_c     = 1'b1;
                end
            end
            FIFO_FULL_STATE: begin
                if (!sel_full)
                    next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)
                    next_state = DECODE_ADDRESS;
                else if (bus.low_pkt_valid)
                    next_state = LOAD_PARITY;
                else
                    next_state = LOAD_DATA;
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                next_state = sel_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
`ifdef ROUTER_WAIT_TIMEOUT_EN
            DROP_PACKET: begin
                if (!bus.pkt_valid)
                    next_state = DECODE_ADDRESS;
            end
`endif
            default: next_state = DECODE_ADDRESS;
        endcase

        // Read-side soft reset of the selected channel abandons the packet.
        if (state != DECODE_ADDRESS && sel_srst) begin
            next_state = DECODE_ADDRESS;
            drop_c     = 1'b0;
        end
    end

    assign bus.detect_addr = (state == DECODE_ADDRESS);
    assign bus.lfd_state   = (state == LOAD_FIRST_DATA);
    assign bus.ld_state    = (state == LOAD_DATA);
    assign bus.laf_state   = (state == LOAD_AFTER_FULL);
    assign bus.full_state  = (state == FIFO_FULL_STATE);
    assign bus.rst_int_reg = (state == CHECK_PARITY_ERROR);
    assign bus.wr_en_req   = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                             (state == LOAD_AFTER_FULL);
    assign bus.busy        = !((state == DECODE_ADDRESS) || (state == LOAD_DATA) ||
                               (state == DROP_PACKET));
    assign bus.sel_ch      = sel_q;
    // addr_err is combinational on pkt_valid, so mask it while reset is held.
    assign bus.addr_err    = addr_err_c & rst;
    assign bus.drop_pkt    = drop_c;

endmodule

// File: tb/tb_router_fsm_nch.sv
// tb_router_fsm_nch -- randomized scoreboard bench for router_fsm_nch.
// The driver applies inputs on the falling edge, predicts the outputs
// from a packet-level reference model and queues them; the monitor
// samples the DUT shortly after and compares against the queue head.
module tb_router_fsm_nch;
    localparam int NCH = 3;
    localparam int AW  = 2;
    localparam int TO  = 4;
`ifdef ROUTER_WAIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // Packet phases of the reference model.
    localparam int P_IDLE = 0, P_FIRST = 1, P_BODY = 2, P_WAIT = 3, P_FULL = 4,
                   P_AFTER = 5, P_PAR = 6, P_CHK = 7, P_DROP = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    router_fsm_nch_if #(.NUM_CH(NCH), .ADDR_W(AW)) bus ();

    router_fsm_nch #(.NUM_CH(NCH), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic          detect, lfd, ld, laf, full, rst_int, wr_en, busy;
        logic [AW-1:0] sel;
        logic          addr_err, drop;
    } obs_t;

    obs_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   running = 1'b1;

    int ph     = P_IDLE;
    int sel    = 0;
    int waited = 0;

    task automatic step(input bit r, input bit pv, input int addr,
                        input logic [NCH-1:0] full, input logic [NCH-1:0] empty,
                        input logic [NCH-1:0] srst, input bit pd, input bit lpv);
        obs_t e;
        int   nph, nsel;
        @(negedge clk);
        rst               = r;
        bus.pkt_valid     = pv;
        bus.din_addr      = AW'(addr);
        bus.fifo_full     = full;
        bus.fifo_empty    = empty;
        bus.soft_rst      = srst;
        bus.parity_done   = pd;
        bus.low_pkt_valid = lpv;

        e         = '0;
        e.detect  = (ph == P_IDLE);
        e.lfd     = (ph == P_FIRST);
        e.ld      = (ph == P_BODY);
        e.laf     = (ph == P_AFTER);
        e.full    = (ph == P_FULL);
        e.rst_int = (ph == P_CHK);
        e.wr_en   = (ph == P_BODY) || (ph == P_PAR) || (ph == P_AFTER);
        e.busy    = !((ph == P_IDLE) || (ph == P_BODY) || (ph == P_DROP));
        e.sel     = AW'(sel);
        if (!r) begin
            e        = '0;
            e.detect = 1'b1;
        end
        e.addr_err = r && ph == P_IDLE && pv && addr >= NCH;
        e.drop     = r && TO_EN && ph == P_WAIT && !empty[sel] && !srst[sel] &&
                     (waited + 1 >= TO);
        sb_q.push_back(e);

        nph  = ph;
        nsel = sel;
        if (!r) begin
            nph  = P_IDLE;
            nsel = 0;
        end else if (ph != P_IDLE && srst[sel]) begin
            nph = P_IDLE;
        end else begin
            case (ph)
                P_IDLE:  if (pv && addr < NCH) begin
                             nsel = addr;
                             nph  = empty[addr] ? P_FIRST : P_WAIT;
                         end
                P_FIRST: nph = P_BODY;
                P_BODY:  nph = full[sel] ? P_FULL : (!pv ? P_PAR : P_BODY);
                P_WAIT:  if (empty[sel]) nph = P_FIRST;
                         else if (e.drop) nph = P_DROP;
                P_FULL:  if (!full[sel]) nph = P_AFTER;
                P_AFTER: nph = pd ? P_IDLE : (lpv ? P_PAR : P_BODY);
                P_PAR:   nph = P_CHK;
                P_CHK:   nph = full[sel] ? P_FULL : P_IDLE;
                P_DROP:  if (!pv) nph = P_IDLE;
                default: nph = P_IDLE;
            endcase
        end
        waited = (ph == P_WAIT && nph == P_WAIT) ? waited + 1 : 0;
        ph     = nph;
        sel    = nsel;
    endtask

    // Monitor: compares every presented cycle against the queued prediction.
    initial begin
        obs_t got, exp;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                exp          = sb_q.pop_front();
                got.detect   = bus.detect_addr;
                got.lfd      = bus.lfd_state;
                got.ld       = bus.ld_state;
                got.laf      = bus.laf_state;
                got.full     = bus.full_state;
                got.rst_int  = bus.rst_int_reg;
                got.wr_en    = bus.wr_en_req;
                got.busy     = bus.busy;
                got.sel      = bus.sel_ch;
                got.addr_err = bus.addr_err;
                got.drop     = bus.drop_pkt;
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL outputs t=%0t got=%b want=%b (det lfd ld laf full rstint wren busy sel aerr drop)",
                             $time, got, exp);
                end
            end else if (running) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty t=%0t got=none want=prediction", $time);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NCH-1:0] f, em, sr;
        bus.pkt_valid = 0; bus.din_addr = '0; bus.fifo_full = '0; bus.fifo_empty = '0;
        bus.soft_rst = '0; bus.parity_done = 0; bus.low_pkt_valid = 0;

        // Reset held with a bad header present: no addr_err, reset decodes.
        repeat (3) step(0, 1, 3, '0, '0, '0, 0, 0);
        // Header to empty channel, then full back-pressure and parity exit.
        step(1, 1, 2, '0,     3'b100, '0, 0, 0);
        step(1, 1, 0, '0,     '0,     '0, 0, 0);
        step(1, 1, 0, 3'b100, '0,     '0, 0, 0);
        step(1, 1, 0, 3'b100, '0,     '0, 0, 0);
        step(1, 0, 0, '0,     '0,     '0, 0, 1);
        step(1, 0, 0, '0,     '0,     '0, 0, 1);
        step(1, 0, 0, '0,     '0,     '0, 0, 0);
        step(1, 0, 0, '0,     '0,     '0, 0, 0);
        // Nonexistent channel.
        step(1, 1, 3, '0,     '0,     '0, 0, 0);
        step(1, 0, 0, '0,     '0,     '0, 0, 0);
        // Wait for channel 1; other channel draining is ignored.
        step(1, 1, 1, '0,     3'b001, '0, 0, 0);
        step(1, 1, 0, '0,     3'b001, '0, 0, 0);
        step(1, 1, 0, '0,     3'b010, '0, 0, 0);
        step(1, 1, 0, '0,     '0,     '0, 0, 0);
        // Soft reset: other channel ignored, selected channel aborts.
        step(1, 1, 0, '0,     '0,     3'b001, 0, 0);
        step(1, 1, 0, '0,     '0,     3'b010, 0, 0);
        step(1, 0, 0, '0,     '0,     '0, 0, 0);
        // Long wait on channel 0 (timeout path when enabled).
        step(1, 1, 0, '0,     3'b110, '0, 0, 0);
        repeat (5) step(1, 1, 0, '0, 3'b110, '0, 0, 0);
        step(1, 0, 0, '0,     3'b110, '0, 0, 0);
        step(1, 0, 0, '0,     3'b111, '0, 0, 0);
        repeat (3) step(1, 0, 0, '0, '0, '0, 0, 0);
        // Reset mid-packet.
        step(1, 1, 2, '0,     3'b100, '0, 0, 0);
        step(1, 1, 0, '0,     '0,     '0, 0, 0);
        step(0, 1, 0, '0,     '0,     '0, 0, 0);
        step(1, 0, 0, '0,     '0,     '0, 0, 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                f[c]  = ($urandom % 6) == 0;
                em[c] = ($urandom % 2) == 0;
                sr[c] = ($urandom % 40) == 0;
            end
            step(($urandom % 150) != 0, ($urandom % 8) != 0, int'($urandom % 4),
                 f, em, sr, ($urandom % 4) == 0, ($urandom % 3) == 0);
        end

        running = 1'b0;
        repeat (2) @(negedge clk);
        #5;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0 queued predictions", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
